// File: rtl/cpu_pkg.sv
// Shared opcodes, FSM encoding and instruction field layout for the ALU sequencer and its ALU.
package cpu_pkg;

  localparam int unsigned DataWidth    = 16;
  localparam int unsigned OpcodeWidth  = 3;
  localparam int unsigned RegAddrWidth = 3;
  localparam int unsigned Imm7Width    = 7;
  localparam int unsigned Imm10Width   = 10;

  localparam int unsigned OpcodeLsb = 13;
  localparam int unsigned RdLsb     = 10;
  localparam int unsigned Rs1Lsb    = 7;
  localparam int unsigned Rs2Lsb    = 4;

  localparam logic [OpcodeWidth-1:0] OpLoad  = 3'b000;
  localparam logic [OpcodeWidth-1:0] OpAdd   = 3'b001;
  localparam logic [OpcodeWidth-1:0] OpAddi  = 3'b010;
  localparam logic [OpcodeWidth-1:0] OpSub   = 3'b011;
  localparam logic [OpcodeWidth-1:0] OpSubi  = 3'b100;
  localparam logic [OpcodeWidth-1:0] OpMul   = 3'b101;
  localparam logic [OpcodeWidth-1:0] OpDisp  = 3'b110;
  localparam logic [OpcodeWidth-1:0] OpClear = 3'b111;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StWb   = 2'd2
  } state_e;

  function automatic logic [OpcodeWidth-1:0] get_op(input logic [DataWidth-1:0] ins);
    return ins[OpcodeLsb +: OpcodeWidth];
  endfunction

  function automatic logic [RegAddrWidth-1:0] get_rd(input logic [DataWidth-1:0] ins);
    return ins[RdLsb +: RegAddrWidth];
  endfunction

  function automatic logic [RegAddrWidth-1:0] get_rs1(input logic [DataWidth-1:0] ins);
    return ins[Rs1Lsb +: RegAddrWidth];
  endfunction

  function automatic logic [RegAddrWidth-1:0] get_rs2(input logic [DataWidth-1:0] ins);
    return ins[Rs2Lsb +: RegAddrWidth];
  endfunction

  function automatic logic [DataWidth-1:0] sext7(input logic [DataWidth-1:0] ins);
    return {{(DataWidth-Imm7Width){ins[Imm7Width-1]}}, ins[Imm7Width-1:0]};
  endfunction

  function automatic logic [DataWidth-1:0] sext10(input logic [DataWidth-1:0] ins);
    return {{(DataWidth-Imm10Width){ins[Imm10Width-1]}}, ins[Imm10Width-1:0]};
  endfunction

  function automatic logic is_alu_op(input logic [OpcodeWidth-1:0] op);
    return (op >= OpAdd) && (op <= OpMul);
  endfunction

  function automatic logic uses_imm7(input logic [OpcodeWidth-1:0] op);
    return (op == OpAddi) || (op == OpSubi);
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 8x16 register file: two async read ports, one sync write port, sync clear-all.
// Define R0_ZERO_EN to hardwire r0 to zero.
module cpu_regfile
  import cpu_pkg::*;
#(
  parameter int unsigned NREGS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [RegAddrWidth-1:0] waddr,
  input  logic [DataWidth-1:0]    wdata,
  input  logic                    clr,
  input  logic [RegAddrWidth-1:0] raddr_a,
  output logic [DataWidth-1:0]    rdata_a,
  input  logic [RegAddrWidth-1:0] raddr_b,
  output logic [DataWidth-1:0]    rdata_b
);

  logic [DataWidth-1:0] regs_q [NREGS];
  logic                 wr_ok;

`ifdef R0_ZERO_EN
  assign wr_ok   = (waddr != '0);
  assign rdata_a = (raddr_a == '0) ? '0 : regs_q[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : regs_q[raddr_b];
`else
  assign wr_ok   = 1'b1;
  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (clr) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we && wr_ok) begin
      regs_q[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Issue/writeback controller for the registered 16-bit ALU; runs LOAD/DISPLAY/CLEAR itself.
// Optional build define: R0_ZERO_EN (r0 hardwired to zero).
module alu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned NREGS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DataWidth-1:0]   instr,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  output logic [OpcodeWidth-1:0] alu_opcode,
  output logic [DataWidth-1:0]   alu_a,
  output logic [DataWidth-1:0]   alu_b,
  input  logic [DataWidth-1:0]   alu_result,
  output logic [DataWidth-1:0]   disp_data,
  output logic                   disp_valid,
  output logic                   done,
  output logic                   busy
);

  state_e                 state_q;
  logic [DataWidth-1:0]   ir_q;
  logic [OpcodeWidth-1:0] alu_opcode_q;
  logic [DataWidth-1:0]   alu_a_q, alu_b_q, disp_data_q;
  logic                   disp_valid_q, done_q, busy_q, ready_q;

  logic [DataWidth-1:0]   rd_src;
  logic [OpcodeWidth-1:0] in_op, ir_op;
  logic [DataWidth-1:0]   rdata_a, rdata_b, wdata;
  logic                   we, clr, accept;

  assign in_op  = get_op(instr);
  assign ir_op  = get_op(ir_q);
  assign accept = instr_valid && ready_q;

  // Operands come from the incoming word at accept, from the latched word afterwards.
  assign rd_src = (state_q == StIdle) ? instr : ir_q;

  always_comb begin
    we    = 1'b0;
    clr   = 1'b0;
    wdata = sext10(ir_q);
    if (state_q == StExec) begin
      we  = (ir_op == OpLoad);
      clr = (ir_op == OpClear);
    end else if (state_q == StWb) begin
      we    = 1'b1;
      wdata = alu_result;
    end
  end

  cpu_regfile #(
    .NREGS(NREGS)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (get_rd(ir_q)),
    .wdata  (wdata),
    .clr    (clr),
    .raddr_a(get_rs1(rd_src)),
    .rdata_a(rdata_a),
    .raddr_b(get_rs2(rd_src)),
    .rdata_b(rdata_b)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      ir_q         <= '0;
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      // ALU inputs are only non-zero for the single EXEC cycle.
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      disp_valid_q <= 1'b0;
      done_q       <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            ir_q    <= instr;
            state_q <= StExec;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            if (is_alu_op(in_op)) begin
              alu_opcode_q <= in_op;
              alu_a_q      <= rdata_a;
              alu_b_q      <= uses_imm7(in_op) ? sext7(instr) : rdata_b;
            end
          end
        end
        StExec: begin
          if (is_alu_op(ir_op)) begin
            state_q <= StWb;
          end else begin
            state_q <= StIdle;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            if (ir_op == OpDisp) begin
              disp_data_q  <= rdata_a;
              disp_valid_q <= 1'b1;
            end
          end
        end
        StWb: begin
          state_q <= StIdle;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign instr_ready = ready_q;
  assign alu_opcode  = alu_opcode_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign disp_data   = disp_data_q;
  assign disp_valid  = disp_valid_q;
  assign done        = done_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed table, corner sequences, random vs. reference model.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [2:0]  alu_opcode;
  logic [15:0] alu_a, alu_b, alu_result, disp_data;
  logic        disp_valid, done, busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .disp_data  (disp_data),
    .disp_valid (disp_valid),
    .done       (done),
    .busy       (busy)
  );

  // Registered ALU, reset together with the sequencer.
  always @(posedge clk or negedge rst) begin
    if (!rst) alu_result <= '0;
    else begin
      case (alu_opcode)
        3'd1, 3'd2: alu_result <= alu_a + alu_b;
        3'd3, 3'd4: alu_result <= alu_a - alu_b;
        3'd5:       alu_result <= alu_a * alu_b;
        default:    alu_result <= '0;
      endcase
    end
  end

  // Reference architectural state.
  logic [15:0] mregs [8];

  task automatic check_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] mk_r(input int op, input int rd, input int rs1, input int rs2);
    logic [15:0] w;
    w = '0;
    w[15:13] = op[2:0]; w[12:10] = rd[2:0]; w[9:7] = rs1[2:0]; w[6:4] = rs2[2:0];
    return w;
  endfunction

  function automatic logic [15:0] mk_i(input int op, input int rd, input int rs1, input int imm);
    logic [15:0] w;
    w = '0;
    w[15:13] = op[2:0]; w[12:10] = rd[2:0]; w[9:7] = rs1[2:0]; w[6:0] = imm[6:0];
    return w;
  endfunction

  function automatic logic [15:0] mk_load(input int rd, input int imm);
    logic [15:0] w;
    w = '0;
    w[12:10] = rd[2:0]; w[9:0] = imm[9:0];
    return w;
  endfunction

  function automatic logic [15:0] m_read(input int r);
`ifdef R0_ZERO_EN
    if (r == 0) return 16'd0;
`endif
    return mregs[r];
  endfunction

  function automatic void m_write(input int r, input logic [15:0] v);
`ifdef R0_ZERO_EN
    if (r == 0) return;
`endif
    mregs[r] = v;
  endfunction

  // Applies one instruction to the model; returns what the DUT should show.
  task automatic m_exec(input logic [15:0] ins, output logic [2:0] eop, output logic [15:0] ea,
                        output logic [15:0] eb, output int elat, output bit edv,
                        output logic [15:0] edd);
    int op, rd, sa, sb, imm7, imm10, res;
    op    = int'(ins[15:13]);
    rd    = int'(ins[12:10]);
    sa    = int'($signed(m_read(int'(ins[9:7]))));
    sb    = int'($signed(m_read(int'(ins[6:4]))));
    imm7  = int'($signed(ins[6:0]));
    imm10 = int'($signed(ins[9:0]));
    eop = 3'd0; ea = '0; eb = '0; elat = 2; edv = 1'b0; edd = '0; res = 0;
    case (op)
      0: m_write(rd, imm10[15:0]);
      6: begin edv = 1'b1; edd = sa[15:0]; end
      7: for (int i = 0; i < 8; i++) mregs[i] = '0;
      default: begin
        eop  = op[2:0];
        elat = 3;
        ea   = sa[15:0];
        if (op == 2 || op == 4) sb = imm7;
        eb = sb[15:0];
        if (op == 1 || op == 2) res = sa + sb;
        else if (op == 3 || op == 4) res = sa - sb;
        else res = sa * sb;
        m_write(rd, res[15:0]);
      end
    endcase
  endtask

  task automatic run_instr(input logic [15:0] ins, input logic [2:0] eop, input logic [15:0] ea,
                           input logic [15:0] eb, input int elat, input bit edv,
                           input logic [15:0] edd, input string nm);
    int n, w, bad;
    w = 0;
    while (!instr_ready && w < 10) begin @(negedge clk); w++; end
    check_eq({nm, " ready"}, 32'(instr_ready), 32'd1);
    instr = ins; instr_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    instr_valid = 1'b0; instr = 16'($urandom);
    check_eq({nm, " exec_op"}, 32'(alu_opcode), 32'(eop));
    check_eq({nm, " exec_a"}, 32'(alu_a), 32'(ea));
    check_eq({nm, " exec_b"}, 32'(alu_b), 32'(eb));
    check_eq({nm, " exec_flags"}, 32'({done, disp_valid, busy}), 32'b001);
    n = 1; bad = 0;
    while (!done && n < 8) begin
      @(posedge clk); @(negedge clk);
      n++;
      if (alu_opcode != 3'd0) bad++;
    end
    check_eq({nm, " latency"}, 32'(n), 32'(elat));
    check_eq({nm, " idle_alu_op"}, 32'(bad), 32'd0);
    check_eq({nm, " disp_valid"}, 32'(disp_valid), 32'(edv));
    if (edv) check_eq({nm, " disp_data"}, 32'(disp_data), 32'(edd));
  endtask

  // Model-predicted expectations throughout.
  task automatic do_instr(input logic [15:0] ins, input string nm);
    logic [2:0] eop; logic [15:0] ea, eb, edd; int elat; bit edv;
    m_exec(ins, eop, ea, eb, elat, edv, edd);
    run_instr(ins, eop, ea, eb, elat, edv, edd, nm);
  endtask

  // Hand-computed latency/display expectations; ALU operands still from the model.
  task automatic do_fixed(input logic [15:0] ins, input int lat, input bit dv,
                          input logic [15:0] dd, input string nm);
    logic [2:0] eop; logic [15:0] ea, eb, edd; int elat; bit edv;
    m_exec(ins, eop, ea, eb, elat, edv, edd);
    run_instr(ins, eop, ea, eb, lat, dv, dd, nm);
  endtask

  typedef struct {
    logic [15:0] ins;
    int          lat;
    bit          dv;
    logic [15:0] dd;
  } vec_t;

  vec_t vecs [14];

  initial begin
    int accepts, w;
    logic [10:0] rmask;
    bit rdy, bad_idle;

    vecs[0]  = '{mk_r(6, 0, 3, 0), 2, 1'b1, 16'd0};
    vecs[1]  = '{mk_load(1, -5), 2, 1'b0, 16'd0};
    vecs[2]  = '{mk_load(2, 7), 2, 1'b0, 16'd0};
    vecs[3]  = '{mk_r(1, 3, 1, 2), 3, 1'b0, 16'd0};
    vecs[4]  = '{mk_r(6, 0, 3, 0), 2, 1'b1, 16'd2};
    vecs[5]  = '{mk_i(4, 4, 1, 63), 3, 1'b0, 16'd0};
    vecs[6]  = '{mk_r(6, 0, 4, 0), 2, 1'b1, 16'hFFBC};
    vecs[7]  = '{mk_r(5, 5, 2, 2), 3, 1'b0, 16'd0};
    vecs[8]  = '{mk_r(6, 0, 5, 0), 2, 1'b1, 16'd49};
    vecs[9]  = '{mk_load(6, 300), 2, 1'b0, 16'd0};
    vecs[10] = '{mk_r(5, 6, 6, 6), 3, 1'b0, 16'd0};
    vecs[11] = '{mk_r(6, 0, 6, 0), 2, 1'b1, 16'd24464};
    vecs[12] = '{mk_load(0, 9), 2, 1'b0, 16'd0};
`ifdef R0_ZERO_EN
    vecs[13] = '{mk_r(6, 0, 0, 0), 2, 1'b1, 16'd0};
`else
    vecs[13] = '{mk_r(6, 0, 0, 0), 2, 1'b1, 16'd9};
`endif
    for (int i = 0; i < 8; i++) mregs[i] = '0;

    // Reset values while held.
    #12;
    check_eq("rst ready", 32'(instr_ready), 32'd1);
    check_eq("rst flags", 32'({done, disp_valid, busy}), 32'd0);
    check_eq("rst alu", 32'({alu_opcode, alu_a, alu_b} != '0), 32'd0);
    check_eq("rst disp_data", 32'(disp_data), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++)
      do_fixed(vecs[i].ins, vecs[i].lat, vecs[i].dv, vecs[i].dd, $sformatf("vec%0d", i));

    // instr_valid held high across four ADD r7,r7,r2 issues.
    instr = mk_r(1, 7, 7, 2); instr_valid = 1'b1;
    accepts = 0; rmask = '0; bad_idle = 1'b0;
    for (int k = 0; k < 11; k++) begin
      rdy = instr_ready;
      rmask[k] = rdy;
      if (rdy && alu_opcode != 3'd0) bad_idle = 1'b1;
      @(posedge clk);
      if (rdy) begin
        logic [2:0] eop; logic [15:0] ea, eb, edd; int elat; bit edv;
        accepts++;
        m_exec(instr, eop, ea, eb, elat, edv, edd);
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    w = 0;
    while (!done && w < 5) begin @(posedge clk); @(negedge clk); w++; end
    check_eq("stream accepts", 32'(accepts), 32'd4);
    check_eq("stream spacing", 32'(rmask), 32'b01001001001);
    check_eq("stream idle_op", 32'(bad_idle), 32'd0);
    check_eq("stream done", 32'(done), 32'd1);
    do_fixed(mk_r(6, 0, 7, 0), 2, 1'b1, 16'd28, "stream r7");

    // Reset during WB of ADD r7.
    instr = mk_r(1, 7, 1, 2); instr_valid = 1'b1;
    @(posedge clk); @(negedge clk); instr_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check_eq("wb busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("abort flags", 32'({done, disp_valid, busy}), 32'd0);
    check_eq("abort ready", 32'(instr_ready), 32'd1);
    check_eq("abort alu", 32'({alu_opcode, alu_a, alu_b} != '0), 32'd0);
    @(posedge clk); #1;
    check_eq("abort no_done", 32'(done), 32'd0);
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    @(negedge clk);
    check_eq("post_rst no_done", 32'(done), 32'd0);
    do_fixed(mk_r(6, 0, 7, 0), 2, 1'b1, 16'd0, "abort r7");
    do_fixed(mk_r(6, 0, 1, 0), 2, 1'b1, 16'd0, "abort r1");

    // CLEAR after several loads.
    do_instr(mk_load(1, 11), "clr ld1");
    do_instr(mk_load(2, -3), "clr ld2");
    do_instr(mk_load(5, 511), "clr ld5");
    do_fixed(mk_r(7, 0, 0, 0), 2, 1'b0, 16'd0, "clear");
    do_fixed(mk_r(6, 0, 2, 0), 2, 1'b1, 16'd0, "clr r2");
    do_fixed(mk_r(6, 0, 5, 0), 2, 1'b1, 16'd0, "clr r5");

    // Random traffic against the model.
    for (int i = 0; i < 60; i++) begin
      logic [15:0] ins;
      ins = 16'($urandom);
      if (ins[15:13] == 3'd7 && ($urandom_range(0, 3) != 0)) ins[15:13] = 3'd0;
      do_instr(ins, $sformatf("rnd%0d", i));
    end
    for (int r = 0; r < 8; r++) do_instr(mk_r(6, 0, r, 0), $sformatf("final r%0d", r));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
